// File: rtl/seq_ctr_checker.sv
// Monitors a free-running counter pattern. It locks after LOCK_COUNT consecutive +1 steps
// and drops lock after LOSS_LIMIT consecutive bad samples.
module seq_ctr_checker #(
    parameter int unsigned WIDTH      = 22,
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned LOSS_LIMIT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pat_in,
    input  logic             clr,
    output logic             locked,
    output logic             err_sticky,
    output logic [7:0]       err_count,
    output logic [15:0]      step_count,
    output logic [1:0]       state_o
);

    if (LOCK_COUNT == 0 || LOSS_LIMIT == 0) begin : g_param_check
        $error("seq_ctr_checker: LOCK_COUNT and LOSS_LIMIT must both be >= 1");
    end

    localparam int unsigned GW = $clog2(LOCK_COUNT + 2);
    localparam int unsigned MW = $clog2(LOSS_LIMIT + 2);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] s_q, p_q, p_d;
    logic             s_vld_q;
    logic [GW-1:0]    good_q, good_d, good_inc;
    logic [MW-1:0]    miss_q, miss_d, miss_inc;
    logic [7:0]       err_q, err_d;
    logic             sticky_q, sticky_d;
    logic [15:0]      step_q, step_d;
    logic             is_hold, is_step;

    assign is_hold  = (s_q == p_q);
    assign is_step  = (s_q == p_q + WIDTH'(1));
    assign good_inc = good_q + GW'(1);
    assign miss_inc = miss_q + MW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= SEARCH;
            s_q      <= '0;
            s_vld_q  <= 1'b0;
            p_q      <= '0;
            good_q   <= '0;
            miss_q   <= '0;
            err_q    <= '0;
            sticky_q <= 1'b0;
            step_q   <= '0;
        end else begin
            state_q  <= state_d;
            s_q      <= pat_in;
            s_vld_q  <= 1'b1;
            p_q      <= p_d;
            good_q   <= good_d;
            miss_q   <= miss_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
            step_q   <= step_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        p_d      = p_q;
        good_d   = good_q;
        miss_d   = miss_q;
        err_d    = err_q;
        sticky_d = sticky_q;
        step_d   = step_q;

        if (s_vld_q) begin
            p_d = s_q;
            case (state_q)
                SEARCH: begin
                    good_d  = '0;
                    miss_d  = '0;
                    state_d = ACQUIRE;
                end
                ACQUIRE: begin
                    if (is_step) begin
                        if (good_inc == GW'(LOCK_COUNT)) begin
                            good_d  = '0;
                            miss_d  = '0;
                            state_d = LOCKED;
                        end else begin
                            good_d = good_inc;
                        end
                    end else if (!is_hold) begin
                        good_d = '0;
                    end
                end
                LOCKED: begin
                    if (is_step) begin
                        step_d = step_q + 16'd1;
                        miss_d = '0;
                    end else if (is_hold) begin
                        miss_d = '0;
                    end else begin
                        err_d    = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
                        sticky_d = 1'b1;
                        if (miss_inc == MW'(LOSS_LIMIT)) begin
                            miss_d  = '0;
                            good_d  = '0;
                            state_d = ACQUIRE;
                        end else begin
                            miss_d = miss_inc;
                        end
                    end
                end
                default: state_d = SEARCH;
            endcase
        end

        // clr only touches the error/step counters and wins over a same-edge update
        if (clr) begin
            err_d    = '0;
            sticky_d = 1'b0;
            step_d   = '0;
        end
    end

    assign locked     = (state_q == LOCKED);
    assign state_o    = state_q;
    assign err_sticky = sticky_q;
    assign err_count  = err_q;
    assign step_count = step_q;

endmodule

// File: tb/tb_seq_ctr_checker.sv
// Directed self-checking bench for seq_ctr_checker (default parameters).
module tb_seq_ctr_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [21:0] pat_in;
    logic        clr;
    logic        locked;
    logic        err_sticky;
    logic [7:0]  err_count;
    logic [15:0] step_count;
    logic [1:0]  state_o;

    logic [27:0] obs;
    logic [27:0] exp;
    int          checks   = 0;
    int          failures = 0;

    seq_ctr_checker #(.WIDTH(22), .LOCK_COUNT(4), .LOSS_LIMIT(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pat_in    (pat_in),
        .clr       (clr),
        .locked    (locked),
        .err_sticky(err_sticky),
        .err_count (err_count),
        .step_count(step_count),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    assign obs = {locked, state_o, err_sticky, err_count, step_count};

    function automatic logic [27:0] exp_vec(input logic l, input logic [1:0] s, input logic st,
                                            input logic [7:0] e, input logic [15:0] sc);
        return {l, s, st, e, sc};
    endfunction

    // Outputs after a drive reflect the classification of the previously driven value.
    task automatic drive(input logic [21:0] v, input logic c);
        pat_in = v;
        clr    = c;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        clr    = 1'b0;
        pat_in = 22'h15;
        repeat (2) @(posedge clk);
        #1;
        exp = '0;
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL reset_state got=%h exp=%h", obs, exp); end
        rst_n = 1'b1;
    endtask

    task automatic test_lockup();
        drive(22'd0, 1'b0);
        exp = exp_vec(1'b0, 2'd0, 1'b0, 8'd0, 16'd0);
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL lockup_search got=%h exp=%h", obs, exp); end
        drive(22'd1, 1'b0);
        exp = exp_vec(1'b0, 2'd1, 1'b0, 8'd0, 16'd0);
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL lockup_acquire got=%h exp=%h", obs, exp); end
        drive(22'd2, 1'b0);
        drive(22'd3, 1'b0);
        drive(22'd4, 1'b0);
        exp = exp_vec(1'b0, 2'd1, 1'b0, 8'd0, 16'd0);
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL lockup_3steps got=%h exp=%h", obs, exp); end
        drive(22'd5, 1'b0);
        exp = exp_vec(1'b1, 2'd2, 1'b0, 8'd0, 16'd0);
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL lockup_locked got=%h exp=%h", obs, exp); end
    endtask

    task automatic test_hold();
        for (int unsigned v = 6; v < 16; v++) drive(22'(v), 1'b0);
        exp = exp_vec(1'b1, 2'd2, 1'b0, 8'd0, 16'd10);
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL hold_steps10 got=%h exp=%h", obs, exp); end
        drive(22'h10, 1'b0);
        drive(22'h10, 1'b1);
        exp = exp_vec(1'b1, 2'd2, 1'b0, 8'd0, 16'd0);
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL hold_clr_prio got=%h exp=%h", obs, exp); end
        repeat (8) drive(22'h10, 1'b0);
        drive(22'h11, 1'b0);
        exp = exp_vec(1'b1, 2'd2, 1'b0, 8'd0, 16'd0);
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL hold_no_count got=%h exp=%h", obs, exp); end
        drive(22'h12, 1'b0);
        exp = exp_vec(1'b1, 2'd2, 1'b0, 8'd0, 16'd1);
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL hold_resume got=%h exp=%h", obs, exp); end
    endtask

    task automatic test_wrap();
        drive(22'h3FFFFE, 1'b0);
        drive(22'h3FFFFF, 1'b1);
        exp = exp_vec(1'b1, 2'd2, 1'b0, 8'd0, 16'd0);
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL wrap_clr_over_bad got=%h exp=%h", obs, exp); end
        drive(22'h000000, 1'b0);
        exp = exp_vec(1'b1, 2'd2, 1'b0, 8'd0, 16'd1);
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL wrap_step1 got=%h exp=%h", obs, exp); end
        drive(22'h000001, 1'b0);
        exp = exp_vec(1'b1, 2'd2, 1'b0, 8'd0, 16'd2);
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL wrap_rollover got=%h exp=%h", obs, exp); end
        drive(22'h000002, 1'b0);
        exp = exp_vec(1'b1, 2'd2, 1'b0, 8'd0, 16'd3);
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL wrap_step3 got=%h exp=%h", obs, exp); end
    endtask

    task automatic test_glitch();
        drive(22'h0000FF, 1'b0);
        drive(22'h000100, 1'b0);
        drive(22'h0000FF, 1'b1);
        exp = exp_vec(1'b1, 2'd2, 1'b0, 8'd0, 16'd0);
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL glitch_setup got=%h exp=%h", obs, exp); end
        drive(22'h000101, 1'b0);
        exp = exp_vec(1'b1, 2'd2, 1'b1, 8'd1, 16'd0);
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL glitch_bad1 got=%h exp=%h", obs, exp); end
        drive(22'h000102, 1'b0);
        exp = exp_vec(1'b1, 2'd2, 1'b1, 8'd2, 16'd0);
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL glitch_resync_bad got=%h exp=%h", obs, exp); end
        drive(22'h000103, 1'b0);
        exp = exp_vec(1'b1, 2'd2, 1'b1, 8'd2, 16'd1);
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL glitch_recover got=%h exp=%h", obs, exp); end
        drive(22'h000104, 1'b1);
        exp = exp_vec(1'b1, 2'd2, 1'b0, 8'd0, 16'd0);
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL glitch_clr got=%h exp=%h", obs, exp); end
    endtask

    task automatic test_loss_of_lock();
        drive(22'h02A5A5, 1'b0);
        drive(22'h000013, 1'b0);
        drive(22'h03C000, 1'b0);
        exp = exp_vec(1'b1, 2'd2, 1'b1, 8'd2, 16'd1);
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL loss_two_bad got=%h exp=%h", obs, exp); end
        drive(22'h000500, 1'b0);
        exp = exp_vec(1'b0, 2'd1, 1'b1, 8'd3, 16'd1);
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL loss_unlock got=%h exp=%h", obs, exp); end
        drive(22'h000501, 1'b0);
        exp = exp_vec(1'b0, 2'd1, 1'b1, 8'd3, 16'd1);
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL loss_acq_bad_noerr got=%h exp=%h", obs, exp); end
        drive(22'h000502, 1'b0);
        drive(22'h000503, 1'b0);
        drive(22'h000504, 1'b0);
        exp = exp_vec(1'b0, 2'd1, 1'b1, 8'd3, 16'd1);
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL loss_acq_3steps got=%h exp=%h", obs, exp); end
        drive(22'h000505, 1'b0);
        exp = exp_vec(1'b1, 2'd2, 1'b1, 8'd3, 16'd1);
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL loss_relock got=%h exp=%h", obs, exp); end
    endtask

    task automatic test_async_reset();
        drive(22'h000700, 1'b0);
        drive(22'h000900, 1'b0);
        drive(22'h000901, 1'b0);
        exp = exp_vec(1'b1, 2'd2, 1'b1, 8'd5, 16'd2);
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL areset_pre got=%h exp=%h", obs, exp); end
        #3;
        rst_n = 1'b0;
        #1;
        exp = '0;
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL areset_immediate got=%h exp=%h", obs, exp); end
        @(posedge clk);
        #1;
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL areset_held got=%h exp=%h", obs, exp); end
        rst_n = 1'b1;
        test_lockup();
    endtask

    initial begin
        test_reset();
        test_lockup();
        test_hold();
        test_wrap();
        test_glitch();
        test_loss_of_lock();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
